// File: rtl/ni_bridge_pkg.sv
// Shared widths, flit field positions and packing helpers for the core/NoC bridge.
// A flit carries the address half-word in its upper half and the payload in its lower half.
package ni_bridge_pkg;

  localparam int ADDRSIZE = 5;
  localparam int MSB_SLOT = 5;
  localparam int DSIZE    = 2 ** MSB_SLOT;
  localparam int RSIZE    = 2 ** (MSB_SLOT - 1);

  localparam int ADDR_HI  = DSIZE - 1;
  localparam int ADDR_LO  = RSIZE;
  localparam int DATA_HI  = RSIZE - 1;
  localparam int DATA_LO  = 0;

  typedef logic [DSIZE-1:0] flit_t;
  typedef logic [RSIZE-1:0] half_t;

  function automatic flit_t pack_flit(input half_t addr, input half_t data);
    flit_t f;
    f = '0;
    f[ADDR_HI:ADDR_LO] = addr;
    f[DATA_HI:DATA_LO] = data;
    return f;
  endfunction

  // lower=0 selects the address (upper) half, lower=1 the payload half
  function automatic half_t flit_half(input flit_t f, input logic lower);
    return lower ? f[DATA_HI:DATA_LO] : f[ADDR_HI:ADDR_LO];
  endfunction

endpackage

// File: rtl/ni_bridge_if.sv
// Core-side and NoC-side handshake signals of the bridge.
// The bridge uses the slave view; whoever drives the core and NoC ports uses master.
interface ni_bridge_if;
  import ni_bridge_pkg::*;

  logic  core_write_en;
  half_t core_wdata;
  half_t core_waddr;
  logic  core_wfull;
  logic  core_read_en;
  half_t core_rdata;
  logic  core_rempty;

  logic  noc_read_en;
  flit_t noc_rdata;
  logic  noc_rempty;
  logic  noc_write_en;
  flit_t noc_wdata;
  logic  noc_wfull;

  modport slave (
    input  core_write_en, core_wdata, core_waddr, core_read_en,
    input  noc_read_en, noc_write_en, noc_wdata,
    output core_wfull, core_rdata, core_rempty,
    output noc_rdata, noc_rempty, noc_wfull
  );

  modport master (
    output core_write_en, core_wdata, core_waddr, core_read_en,
    output noc_read_en, noc_write_en, noc_wdata,
    input  core_wfull, core_rdata, core_rempty,
    input  noc_rdata, noc_rempty, noc_wfull
  );

endinterface

// File: rtl/ni_bridge_sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO; the head entry is read combinationally
// from the registered read pointer, and the flags come from a registered occupancy count.
module sync_fifo_fwft #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_en,
  input  logic [WIDTH-1:0] wdata,
  output logic             wfull,
  input  logic             read_en,
  output logic [WIDTH-1:0] rdata,
  output logic             rempty
);

  localparam logic [ADDRSIZE:0] FULL_COUNT = {1'b1, {ADDRSIZE{1'b0}}};

  logic [WIDTH-1:0]    mem [2**ADDRSIZE];
  logic [ADDRSIZE-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDRSIZE-1:0] rd_ptr_reg, rd_ptr_next;
  logic [ADDRSIZE:0]   count_reg, count_next;
  logic                do_write, do_read;

  assign rempty   = (count_reg == '0);
  assign wfull    = (count_reg == FULL_COUNT);
  assign do_write = write_en && !wfull;
  assign do_read  = read_en && !rempty;
  // Empty reads as zero so stale or never-written entries never leak out
  assign rdata    = rempty ? '0 : mem[rd_ptr_reg];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_write) wr_ptr_next = wr_ptr_reg + ADDRSIZE'(1);
    if (do_read)  rd_ptr_next = rd_ptr_reg + ADDRSIZE'(1);
    case ({do_write, do_read})
      2'b10:   count_next = count_reg + (ADDRSIZE+1)'(1);
      2'b01:   count_next = count_reg - (ADDRSIZE+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/ni_bridge.sv
// Network interface bridge: packs core {addr, data} half-words into TX flits and
// hands received flits to the core one half-word at a time, upper half first.
module ni_bridge
  import ni_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  ni_bridge_if.slave  bus
);

  flit_t tx_flit;
  flit_t rx_head;
  logic  rx_empty;
  logic  rx_pop;
  logic  half_sel_reg, half_sel_next;

  assign tx_flit = pack_flit(bus.core_waddr, bus.core_wdata);

  sync_fifo_fwft #(.WIDTH(DSIZE), .ADDRSIZE(ADDRSIZE)) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .write_en (bus.core_write_en),
    .wdata    (tx_flit),
    .wfull    (bus.core_wfull),
    .read_en  (bus.noc_read_en),
    .rdata    (bus.noc_rdata),
    .rempty   (bus.noc_rempty)
  );

  sync_fifo_fwft #(.WIDTH(DSIZE), .ADDRSIZE(ADDRSIZE)) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .write_en (bus.noc_write_en),
    .wdata    (bus.noc_wdata),
    .wfull    (bus.noc_wfull),
    .read_en  (rx_pop),
    .rdata    (rx_head),
    .rempty   (rx_empty)
  );

  // The flit leaves the RX FIFO only once its lower half has been consumed
  assign rx_pop = bus.core_read_en && !rx_empty && half_sel_reg;

  always_comb begin
    half_sel_next = half_sel_reg;
    if (bus.core_read_en && !rx_empty) half_sel_next = !half_sel_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) half_sel_reg <= 1'b0;
    else       half_sel_reg <= half_sel_next;
  end

  assign bus.core_rdata  = flit_half(rx_head, half_sel_reg);
  assign bus.core_rempty = rx_empty;

endmodule

// File: tb/tb_ni_bridge.sv
// Self-checking bench for ni_bridge: directed scenarios plus randomized traffic
// compared against a queue-based model of the two FIFOs and the half-word reader.
module tb_ni_bridge;
  import ni_bridge_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  ni_bridge_if bus ();

  ni_bridge dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: queues of whole flits and the half-word cursor
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  bit          hs_m;

  function automatic logic [31:0] exp_noc_rdata();
    return (tx_q.size() == 0) ? 32'h0 : tx_q[0];
  endfunction

  function automatic logic [15:0] exp_core_rdata();
    logic [31:0] f;
    if (rx_q.size() == 0) return 16'h0;
    f = rx_q[0];
    return hs_m ? f[15:0] : f[31:16];
  endfunction

  task automatic drive(input logic cw, input logic [15:0] wa, input logic [15:0] wd,
                       input logic cr, input logic nr, input logic nw, input logic [31:0] nd);
    bus.core_write_en = cw;
    bus.core_waddr    = wa;
    bus.core_wdata    = wd;
    bus.core_read_en  = cr;
    bus.noc_read_en   = nr;
    bus.noc_write_en  = nw;
    bus.noc_wdata     = nd;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Advance the model with the currently driven inputs, then take one clock edge
  task automatic tick();
    bit txe, txf, rxe, rxf;
    txe = (tx_q.size() == 0);
    txf = (tx_q.size() == 32);
    rxe = (rx_q.size() == 0);
    rxf = (rx_q.size() == 32);
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      hs_m = 1'b0;
    end else begin
      if (bus.noc_read_en && !txe) void'(tx_q.pop_front());
      if (bus.core_write_en && !txf) tx_q.push_back({bus.core_waddr, bus.core_wdata});
      if (bus.core_read_en && !rxe) begin
        if (hs_m) begin
          void'(rx_q.pop_front());
          hs_m = 1'b0;
        end else begin
          hs_m = 1'b1;
        end
      end
      if (bus.noc_write_en && !rxf) rx_q.push_back(bus.noc_wdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({bus.noc_rempty, bus.core_rempty, bus.core_wfull, bus.noc_wfull} !== 4'b1100) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 1100",
               {bus.noc_rempty, bus.core_rempty, bus.core_wfull, bus.noc_wfull});
    end
    tests_run++;
    if ({bus.noc_rdata, bus.core_rdata} !== 48'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got %h expected 0", {bus.noc_rdata, bus.core_rdata});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    drive(1'b1, 16'hBBBB, 16'hAAAA, 1'b0, 1'b0, 1'b1, 32'hABABABAB);
    tick();
    idle();
    tests_run++;
    if (bus.noc_rdata !== 32'hBBBBAAAA || bus.noc_rempty !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_tx: got %h/%b expected bbbbaaaa/0", bus.noc_rdata, bus.noc_rempty);
    end
    tests_run++;
    if (bus.core_rdata !== 16'hABAB || bus.core_rempty !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_rx: got %h/%b expected abab/0", bus.core_rdata, bus.core_rempty);
    end
  endtask

  task automatic test_drain();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    tests_run++;
    if (bus.noc_rempty !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_tx_empty: got %b expected 1", bus.noc_rempty);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tests_run++;
    if (bus.core_rdata !== 16'hABAB || bus.core_rempty !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_lower: got %h/%b expected abab/0", bus.core_rdata, bus.core_rempty);
    end
    tick();
    idle();
    tests_run++;
    if (bus.core_rempty !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_rx_empty: got %b expected 1", bus.core_rempty);
    end
  endtask

  task automatic test_rx_full();
    for (int i = 0; i < 32; i++) begin
      tests_run++;
      if (bus.noc_wfull !== 1'b0) begin
        tests_failed++;
        $display("FAIL rx_not_full_%0d: got %b expected 0", i, bus.noc_wfull);
      end
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 32'(i));
      tick();
    end
    tests_run++;
    if (bus.noc_wfull !== 1'b1) begin
      tests_failed++;
      $display("FAIL rx_full: got %b expected 1", bus.noc_wfull);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    tick();
    for (int k = 0; k < 64; k++) begin
      logic [15:0] exp_half;
      exp_half = (k % 2 == 1) ? 16'(k / 2) : 16'h0;
      tests_run++;
      if (bus.core_rdata !== exp_half || bus.core_rempty !== 1'b0) begin
        tests_failed++;
        $display("FAIL rx_order_%0d: got %h/%b expected %h/0", k, bus.core_rdata, bus.core_rempty, exp_half);
      end
      drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 32'h0);
      tick();
    end
    idle();
    tests_run++;
    if (bus.core_rempty !== 1'b1 || bus.noc_wfull !== 1'b0) begin
      tests_failed++;
      $display("FAIL rx_overflow_dropped: got rempty=%b wfull=%b expected 1/0", bus.core_rempty, bus.noc_wfull);
    end
  endtask

  task automatic test_tx_full();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 16'hC000 | 16'(i), 16'(i * 3), 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
    end
    idle();
    tests_run++;
    if (bus.core_wfull !== 1'b1) begin
      tests_failed++;
      $display("FAIL tx_full: got %b expected 1", bus.core_wfull);
    end
    drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    idle();
    tests_run++;
    if (bus.core_wfull !== 1'b0 || bus.noc_rdata !== {16'hC001, 16'd3}) begin
      tests_failed++;
      $display("FAIL tx_full_rw: got wfull=%b head=%h expected 0/c0010003", bus.core_wfull, bus.noc_rdata);
    end
    for (int i = 1; i < 32; i++) begin
      tests_run++;
      if (bus.noc_rdata !== {16'hC000 | 16'(i), 16'(i * 3)}) begin
        tests_failed++;
        $display("FAIL tx_full_order_%0d: got %h expected %h", i, bus.noc_rdata, {16'hC000 | 16'(i), 16'(i * 3)});
      end
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0);
      tick();
    end
    drive(1'b1, 16'h1234, 16'h5678, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    idle();
    tests_run++;
    if (bus.noc_rempty !== 1'b0 || bus.noc_rdata !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL tx_empty_rw: got %b/%h expected 0/12345678", bus.noc_rempty, bus.noc_rdata);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 1; i <= 40; i++) begin
      tests_run++;
      if (bus.noc_rdata !== {16'h0100, 16'(i - 1)}) begin
        tests_failed++;
        $display("FAIL b2b_head_%0d: got %h expected %h", i, bus.noc_rdata, {16'h0100, 16'(i - 1)});
      end
      drive(1'b1, 16'h0100, 16'(i), 1'b0, 1'b1, 1'b0, 32'h0);
      tick();
      tests_run++;
      if (bus.noc_rempty !== 1'b0 || bus.core_wfull !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_count_%0d: got rempty=%b wfull=%b expected 0/0", i, bus.noc_rempty, bus.core_wfull);
      end
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    tests_run++;
    if (bus.noc_rdata !== {16'h0100, 16'd40}) begin
      tests_failed++;
      $display("FAIL b2b_last: got %h expected 01000028", bus.noc_rdata);
    end
    tick();
    idle();
    tests_run++;
    if (bus.noc_rempty !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_empty: got %b expected 1", bus.noc_rempty);
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 32'h12345678);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 32'h9ABCDEF0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    tests_run++;
    if (bus.core_rdata !== 16'h5678) begin
      tests_failed++;
      $display("FAIL mid_half_read: got %h expected 5678", bus.core_rdata);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (bus.core_rempty !== 1'b1 || bus.core_rdata !== 16'h0) begin
      tests_failed++;
      $display("FAIL mid_async_reset: got %b/%h expected 1/0000", bus.core_rempty, bus.core_rdata);
    end
    tick();
    reset = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
    tick();
    idle();
    tests_run++;
    if (bus.core_rdata !== 16'hCAFE) begin
      tests_failed++;
      $display("FAIL mid_upper_first: got %h expected cafe", bus.core_rdata);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tests_run++;
    if (bus.core_rdata !== 16'hF00D) begin
      tests_failed++;
      $display("FAIL mid_lower: got %h expected f00d", bus.core_rdata);
    end
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [51:0] got, exp;
    for (int c = 0; c < 400; c++) begin
      int pw, pr;
      pw = (c < 200) ? 75 : 35;
      pr = (c < 200) ? 35 : 75;
      drive(($urandom_range(99) < 32'(pw)), 16'($urandom), 16'($urandom),
            ($urandom_range(99) < 32'(pr)), ($urandom_range(99) < 32'(pr)),
            ($urandom_range(99) < 32'(pw)), $urandom);
      $display("[TB] rnd %0d cw=%b cr=%b nr=%b nw=%b tx=%0d rx=%0d", c, bus.core_write_en,
               bus.core_read_en, bus.noc_read_en, bus.noc_write_en, tx_q.size(), rx_q.size());
      tick();
      exp = {exp_noc_rdata(), tx_q.size() == 0, tx_q.size() == 32,
             exp_core_rdata(), rx_q.size() == 0, rx_q.size() == 32};
      got = {bus.noc_rdata, bus.noc_rempty, bus.core_wfull,
             bus.core_rdata, bus.core_rempty, bus.noc_wfull};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL random_%0d: got %h expected %h", c, got, exp);
      end
    end
    idle();
  endtask

  initial begin
    hs_m = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_drain();
    test_rx_full();
    test_tx_full();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ni_bridge.md
Name: ni_bridge

Overview:
- Minimal network interface between a processing core and a NoC router port.
- Core-side writes {address, data} half-words. Each pair is packed into one NoC flit and queued in a TX FIFO that the NoC drains.
- NoC-side writes full flits into an RX FIFO. The core drains it one half-word at a time, upper half first.
- Single clock domain. Both FIFOs are synchronous and first-word-fall-through (FWFT).

Parameters:
- ADDRSIZE, 5, FIFO pointer width; each FIFO depth = 2**ADDRSIZE (32 entries).
- MSB_SLOT, 5, flit width exponent; DSIZE = 2**MSB_SLOT (32 bits), RSIZE = 2**(MSB_SLOT-1) (16 bits). Derived, not overridable separately.

Ports:
- clk, in, 1, sole clock; all state on rising edge.
- reset, in, 1, asynchronous active-high reset.
- core_write_en, in, 1, push {core_waddr, core_wdata} into TX FIFO.
- core_wdata, in, RSIZE, payload half-word.
- core_waddr, in, RSIZE, destination/address half-word.
- core_wfull, out, 1, TX FIFO full.
- core_read_en, in, 1, consume one RX half-word.
- core_rdata, out, RSIZE, current RX half-word (FWFT).
- core_rempty, out, 1, RX FIFO empty.
- noc_read_en, in, 1, pop one TX flit.
- noc_rdata, out, DSIZE, head TX flit (FWFT).
- noc_rempty, out, 1, TX FIFO empty.
- noc_write_en, in, 1, push noc_wdata into RX FIFO.
- noc_wdata, in, DSIZE, incoming flit.
- noc_wfull, out, 1, RX FIFO full.

Behaviour:
- Reset (async assert, sync release): pointers, counts and half_sel cleared.
- During reset: core_rempty=1, noc_rempty=1, core_wfull=0, noc_wfull=0. noc_rdata and core_rdata are don't-care (implement as 0).
- TX flit format: flit = {core_waddr, core_wdata}, address in bits [DSIZE-1:RSIZE].
- Write: on posedge, if write_en and not full, store at write pointer and increment. Write while full is dropped with no state change.
- Read: on posedge, if read_en and not empty, increment read pointer. Read while empty is ignored.
- FWFT: head entry is visible on rdata combinationally from the registered read pointer.
- Latency: a word written at edge N is visible with rempty=0 after edge N (one cycle).
- Flags derive from registered occupancy count (ADDRSIZE+1 bits): empty when count==0, full when count==2**ADDRSIZE.
- Simultaneous read and write on a non-empty, non-full FIFO: both happen, count unchanged.
- Simultaneous read and write when empty: only the write takes effect.
- Simultaneous read and write when full: the read succeeds and the write is dropped (flags are the start-of-cycle values).
- Pointers wrap modulo 2**ADDRSIZE.
- RX core path: core_rdata = half_sel ? rx_head[RSIZE-1:0] : rx_head[DSIZE-1:RSIZE].
- On core_read_en with RX non-empty: if half_sel==0, set half_sel=1 with no pop; else pop the RX FIFO and clear half_sel.
- core_rempty mirrors the RX FIFO empty flag.
- Reset mid-operation discards all queued data immediately, including a half-consumed flit.

Decomposition:
- Shared package: DSIZE/RSIZE derivation and flit field positions (ADDR_HI/LO, DATA_HI/LO).
- One sub-module: sync_fifo_fwft (WIDTH, ADDRSIZE), instantiated twice (TX width DSIZE, RX width DSIZE).
- Top level adds packing, the half-word unpacker and the half_sel register.

Test Plan:
- Reset held 2 cycles -> noc_rempty=1, core_rempty=1, core_wfull=0, noc_wfull=0.
- One cycle with core_write_en=1, core_wdata=16'hAAAA, core_waddr=16'hBBBB, plus noc_write_en=1, noc_wdata=32'hABABABAB -> next cycle noc_rdata=32'hBBBBAAAA, noc_rempty=0, core_rdata=16'hABAB, core_rempty=0.
- noc_read_en=1 for one cycle, then two cycles of core_read_en=1 -> noc_rempty=1; core_rdata shows ABAB (upper) then ABAB (lower); core_rempty=1 after the second read.
- Push 32 flits 0..31 via noc_write_en -> noc_wfull=1; 33rd write dropped. Drain 64 half-reads -> order preserved, the last flit read is 31.
- Simultaneous write and read with TX holding 1 entry -> count stays 1, data order preserved. Pointer wrap verified after 40 push/pop pairs.
- Assert reset after one core half-read of a flit -> core_rempty=1, half_sel cleared; the next flit is read upper half first.
